sync_timer_multi: RTL and testbench

- Parametrised successor of the auto-sync timer. Measures the arrival times of up to PULSE_NUM toggle edges on two sync_in sample paths: the bus-sampled path (CDC'd into clock_det) and the det-sampled path.
- Wait and timeout thresholds are runtime inputs. Adds abort-on-disable, a busy flag and per-path edge counts.
- Sits in the clock_det domain between the sync_in samplers and the control/status registers.

---
 rtl/sync_timer_multi.sv | 190 +++++++++++++++++++
 tb/tb_sync_timer_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_timer_multi.sv
// Multi-pulse auto-sync timer: timestamps up to PULSE_NUM toggle edges on the bus- and det-sampled paths.
// Optional trigger output built only when SYNC_TIMER_TRIG_EN is defined.
module sync_timer_multi #(
  parameter int TIME_BITS = 16,
  parameter int PULSE_NUM = 2,
  parameter int CNT_BITS  = $clog2(PULSE_NUM)
) (
  input  logic                               clock_det,
  input  logic                               reset_det,
  input  logic                               as_en,
  input  logic                               as_prim,
  input  logic [TIME_BITS-1:0]               as_wait,
  input  logic [TIME_BITS-1:0]               as_tmax,
  input  logic [TIME_BITS-1:0]               as_trig_at,
  input  logic                               sync_in_tgl_bus,
  input  logic                               sync_in_tgl_det,
  output logic                               sync_mon,
  output logic                               as_busy,
  output logic                               as_done,
  output logic                               as_timeout,
  output logic                               as_trig,
  output logic [CNT_BITS:0]                  cnt_bus,
  output logic [CNT_BITS:0]                  cnt_det,
  output logic [2*PULSE_NUM*TIME_BITS-1:0]   sync_time
);

  localparam logic [CNT_BITS:0]  FULL    = (CNT_BITS+1)'(PULSE_NUM);
  localparam logic [TIME_BITS-1:0] ONE   = TIME_BITS'(1);

  typedef enum logic [2:0] {IDLE, PRIM_WAIT, SEC_WAIT, TIMER, OUTPUT} state_t;

  state_t               state_reg, state_next;
  logic [TIME_BITS-1:0] counter_reg, counter_next;
  logic [TIME_BITS-1:0] wait_reg, tmax_reg;
  logic [CNT_BITS:0]    cnt_bus_reg, cnt_det_reg;
  logic                 en_reg, bus_reg, det_reg;
  logic                 timeout_reg, timeout_next;
  logic                 mon_reg, mon_next;
  logic                 clear, latch, rec_en;

  logic edge_bus, edge_det, start, abort, incomplete;

  assign edge_bus   = bus_reg != sync_in_tgl_bus;
  assign edge_det   = det_reg != sync_in_tgl_det;
  assign start      = as_en && !en_reg;
  assign abort      = !as_en && (state_reg == PRIM_WAIT || state_reg == SEC_WAIT || state_reg == TIMER);
  assign incomplete = (cnt_bus_reg < FULL) || (cnt_det_reg < FULL);

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    timeout_next = timeout_reg;
    mon_next     = 1'b0;
    clear        = 1'b0;
    latch        = 1'b0;
    rec_en       = 1'b0;
    if (abort) begin
      state_next   = IDLE;
      counter_next = ONE;
      clear        = 1'b1;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          counter_next = ONE;
          if (start) begin
            clear        = 1'b1;
            latch        = 1'b1;
            mon_next     = 1'b1;
            timeout_next = 1'b0;
            state_next   = as_prim ? PRIM_WAIT : SEC_WAIT;
          end
        end
        PRIM_WAIT: begin
          if (counter_reg == tmax_reg) begin
            state_next   = OUTPUT;
            timeout_next = incomplete;
          end else begin
            counter_next = counter_reg + ONE;
            if (counter_reg >= wait_reg) state_next = TIMER;
          end
        end
        SEC_WAIT: begin
          if (edge_det) begin
            mon_next     = 1'b1;
            state_next   = TIMER;
            counter_next = ONE;
          end
        end
        TIMER: begin
          mon_next = edge_det;
          // Timeout wins over completion and suppresses recording in its cycle.
          if (counter_reg == tmax_reg) begin
            state_next   = OUTPUT;
            timeout_next = incomplete;
          end else if (!incomplete) begin
            state_next   = OUTPUT;
            timeout_next = 1'b0;
          end else begin
            rec_en       = 1'b1;
            counter_next = counter_reg + ONE;
          end
        end
        OUTPUT: begin
          state_next   = IDLE;
          counter_next = ONE;
        end
        default: begin
          state_next   = IDLE;
          counter_next = ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_det) begin
    if (reset_det) begin
      state_reg   <= IDLE;
      counter_reg <= ONE;
      wait_reg    <= ONE;
      tmax_reg    <= '1;
      en_reg      <= 1'b0;
      bus_reg     <= 1'b0;
      det_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      mon_reg     <= 1'b0;
      cnt_bus_reg <= '0;
      cnt_det_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      en_reg      <= as_en;
      bus_reg     <= sync_in_tgl_bus;
      det_reg     <= sync_in_tgl_det;
      timeout_reg <= timeout_next;
      mon_reg     <= mon_next;
      if (latch) begin
        wait_reg <= (as_wait == '0) ? ONE : as_wait;
        tmax_reg <= (as_tmax == '0) ? '1 : as_tmax;
      end
      if (clear) begin
        cnt_bus_reg <= '0;
        cnt_det_reg <= '0;
      end else if (rec_en) begin
        if (edge_bus && cnt_bus_reg < FULL) cnt_bus_reg <= cnt_bus_reg + 1'b1;
        if (edge_det && cnt_det_reg < FULL) cnt_det_reg <= cnt_det_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PULSE_NUM; gi++) begin : g_slot
      localparam logic [CNT_BITS:0] SLOT_IDX = (CNT_BITS+1)'(gi);
      logic [TIME_BITS-1:0] slot_bus_reg, slot_det_reg;
      always_ff @(posedge clock_det) begin
        if (reset_det || clear) begin
          slot_bus_reg <= '0;
          slot_det_reg <= '0;
        end else if (rec_en) begin
          if (edge_bus && cnt_bus_reg == SLOT_IDX) slot_bus_reg <= counter_reg;
          if (edge_det && cnt_det_reg == SLOT_IDX) slot_det_reg <= counter_reg;
        end
      end
      assign sync_time[gi*TIME_BITS +: TIME_BITS]               = slot_bus_reg;
      assign sync_time[(PULSE_NUM+gi)*TIME_BITS +: TIME_BITS]   = slot_det_reg;
    end
  endgenerate

`ifdef SYNC_TIMER_TRIG_EN
  logic [TIME_BITS-1:0] trig_at_reg;
  always_ff @(posedge clock_det) begin
    if (reset_det)  trig_at_reg <= '0;
    else if (latch) trig_at_reg <= as_trig_at;
  end
  assign as_trig = (state_reg == TIMER) && (trig_at_reg != '0) && (counter_reg == trig_at_reg);
`else
  logic unused_trig_at;
  assign unused_trig_at = ^as_trig_at;
  assign as_trig        = 1'b0;
`endif

  assign sync_mon   = mon_reg;
  assign as_busy    = state_reg != IDLE;
  assign as_done    = state_reg == OUTPUT;
  assign as_timeout = timeout_reg;
  assign cnt_bus    = cnt_bus_reg;
  assign cnt_det    = cnt_det_reg;

endmodule

// File: tb/tb_sync_timer_multi.sv
// Self-checking bench for sync_timer_multi: directed scenarios plus random runs against a behavioural model.
module tb_sync_timer_multi;
  localparam int TB = 16;
  localparam int PN = 2;
  localparam int CB = $clog2(PN);
  localparam int SW = 2*PN*TB;
  localparam int ALL_ONES = (1 << TB) - 1;
`ifdef SYNC_TIMER_TRIG_EN
  localparam logic TRIG_ON = 1'b1;
`else
  localparam logic TRIG_ON = 1'b0;
`endif

  logic          clock_det = 1'b0;
  logic          reset_det, as_en, as_prim, bus, det;
  logic [TB-1:0] as_wait, as_tmax, as_trig_at;
  logic          sync_mon, as_busy, as_done, as_timeout, as_trig;
  logic [CB:0]   cnt_bus, cnt_det;
  logic [SW-1:0] sync_time;

  sync_timer_multi #(.TIME_BITS(TB), .PULSE_NUM(PN)) dut (
    .clock_det(clock_det), .reset_det(reset_det), .as_en(as_en), .as_prim(as_prim),
    .as_wait(as_wait), .as_tmax(as_tmax), .as_trig_at(as_trig_at),
    .sync_in_tgl_bus(bus), .sync_in_tgl_det(det),
    .sync_mon(sync_mon), .as_busy(as_busy), .as_done(as_done), .as_timeout(as_timeout),
    .as_trig(as_trig), .cnt_bus(cnt_bus), .cnt_det(cnt_det), .sync_time(sync_time));

  always #5 clock_det = ~clock_det;

  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_mon = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 pre-wait, 2 wait-for-det, 3 timing, 4 result cycle.
  int m_phase = 0, m_cnt = 1, m_wait = 1, m_tmax = ALL_ONES, m_trig_at = 0;
  int m_bus[PN], m_det[PN];
  int m_cb = 0, m_cd = 0, m_to = 0, m_mon = 0;
  bit m_pen, m_pb, m_pd, m_valid = 0;

  task automatic m_clear();
    for (int i = 0; i < PN; i++) begin m_bus[i] = 0; m_det[i] = 0; end
    m_cb = 0; m_cd = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit eb, ed, st, inc;
    if (reset_det) begin
      m_phase = 0; m_cnt = 1; m_clear(); m_mon = 0; m_trig_at = 0;
      m_pen = 0; m_pb = 0; m_pd = 0; m_valid = 1;
      return;
    end
    eb  = bus != m_pb;
    ed  = det != m_pd;
    st  = as_en && !m_pen;
    inc = (m_cb < PN) || (m_cd < PN);
    m_mon = 0;
    if (m_phase >= 1 && m_phase <= 3 && !as_en) begin
      m_phase = 0; m_cnt = 1; m_clear();
    end else begin
      case (m_phase)
        0: begin
          m_cnt = 1;
          if (st) begin
            m_clear(); m_mon = 1;
            m_wait    = (as_wait == 0) ? 1 : int'(as_wait);
            m_tmax    = (as_tmax == 0) ? ALL_ONES : int'(as_tmax);
            m_trig_at = int'(as_trig_at);
            m_phase   = as_prim ? 1 : 2;
          end
        end
        1: begin
          if (m_cnt == m_tmax) begin m_phase = 4; m_to = inc; end
          else begin
            if (m_cnt >= m_wait) m_phase = 3;
            m_cnt++;
          end
        end
        2: if (ed) begin m_mon = 1; m_phase = 3; m_cnt = 1; end
        3: begin
          m_mon = ed;
          if (m_cnt == m_tmax) begin m_phase = 4; m_to = inc; end
          else if (!inc) begin m_phase = 4; m_to = 0; end
          else begin
            if (eb && m_cb < PN) begin m_bus[m_cb] = m_cnt; m_cb++; end
            if (ed && m_cd < PN) begin m_det[m_cd] = m_cnt; m_cd++; end
            m_cnt++;
          end
        end
        default: begin m_phase = 0; m_cnt = 1; end
      endcase
    end
    m_pen = as_en; m_pb = bus; m_pd = det;
  endtask

  task automatic compare();
    logic [SW-1:0] exp_time;
    logic          exp_trig;
    for (int i = 0; i < PN; i++) begin
      exp_time[i*TB +: TB]      = TB'(m_bus[i]);
      exp_time[(PN+i)*TB +: TB] = TB'(m_det[i]);
    end
    exp_trig = TRIG_ON && m_phase == 3 && m_trig_at != 0 && m_cnt == m_trig_at;
    chk("busy", as_busy, m_phase != 0);
    chk("done", as_done, m_phase == 4);
    chk("timeout", as_timeout, m_to);
    chk("sync_mon", sync_mon, m_mon);
    chk("trig", as_trig, exp_trig);
    chk("cnt_bus", cnt_bus, m_cb);
    chk("cnt_det", cnt_det, m_cd);
    chk("sync_time", sync_time, exp_time);
    if (as_done) n_done++;
    if (sync_mon) n_mon++;
  endtask

  initial begin
    forever begin
      @(negedge clock_det);
      if (m_valid) compare();
      model_step();
    end
  end

  int cur;
  task automatic cyc(input int n);
    repeat (n) @(posedge clock_det);
    #1;
  endtask
  task automatic go_to(input int c);
    cyc(c - cur);
    cur = c;
  endtask
  task automatic start_run(input bit prim, input int w, input int tm, input int tr);
    as_en = 0;
    cyc(1);
    as_prim = prim; as_wait = TB'(w); as_tmax = TB'(tm); as_trig_at = TB'(tr);
    as_en = 1;
    cyc(1);
    cur = 1;
  endtask

  int d0, m0;
  initial begin
    reset_det = 1; as_en = 0; as_prim = 0; as_wait = 0; as_tmax = 0; as_trig_at = 0;
    bus = 0; det = 0;
    cyc(3);
    reset_det = 0;
    cyc(1);
    chk("reset_busy", as_busy, 0);
    chk("reset_time", sync_time, 0);
    chk("reset_cnt", {cnt_bus, cnt_det}, 0);

    // Primary run
    d0 = n_done;
    start_run(1, 8, 100, 0);
    go_to(12); bus = ~bus;
    go_to(13); det = ~det;
    go_to(20); bus = ~bus;
    go_to(21); det = ~det;
    go_to(22); chk("prim_busy_22", as_busy, 1);
    cyc(1);    chk("prim_done", as_done, 1); chk("prim_timeout", as_timeout, 0);
    cyc(1);    chk("prim_busy_after", as_busy, 0);
    chk("prim_time", sync_time, {16'd21, 16'd13, 16'd20, 16'd12});
    chk("prim_cnt", {cnt_bus, cnt_det}, {2'd2, 2'd2});
    chk("model_bus0", m_bus[0], 12);
    chk("model_det1", m_det[1], 21);
    cyc(2);    chk("prim_done_pulses", n_done - d0, 1);

    // Secondary run
    d0 = n_done; m0 = n_mon;
    start_run(0, 0, 0, 0);
    cyc(2); det = ~det;
    cyc(1); cur = 1;
    go_to(5);  bus = ~bus;
    go_to(6);  det = ~det;
    go_to(9);  bus = ~bus;
    go_to(10); det = ~det;
    cyc(4);
    chk("sec_time", sync_time, {16'd10, 16'd6, 16'd9, 16'd5});
    chk("sec_mon_pulses", n_mon - m0, 4);
    chk("sec_done_pulses", n_done - d0, 1);

    // Timeout
    start_run(1, 4, 30, 0);
    go_to(15); bus = ~bus;
    go_to(30); chk("to_done_early", as_done, 0);
    cyc(1);    chk("to_done", as_done, 1); chk("to_timeout", as_timeout, 1);
    cyc(1);
    chk("to_time", sync_time, 64'h0000_0000_0000_000F);
    chk("to_cnt", {cnt_bus, cnt_det}, {2'd1, 2'd0});
    chk("to_timeout_held", as_timeout, 1);

    // Simultaneous edges and overflow
    start_run(1, 3, 200, 0);
    go_to(7);  bus = ~bus; det = ~det;
    go_to(9);  bus = ~bus;
    go_to(11); bus = ~bus;
    go_to(13); bus = ~bus;
    go_to(15); det = ~det;
    cyc(4);
    chk("sim_time", sync_time, {16'd15, 16'd7, 16'd9, 16'd7});
    chk("sim_timeout", as_timeout, 0);

    // Abort
    d0 = n_done;
    start_run(1, 3, 100, 0);
    go_to(5);  bus = ~bus;
    go_to(10); as_en = 0;
    cyc(1);
    chk("abort_busy", as_busy, 0);
    chk("abort_time", sync_time, 0);
    chk("abort_cnt", {cnt_bus, cnt_det}, 0);
    chk("abort_timeout", as_timeout, 0);
    cyc(2); chk("abort_no_done", n_done - d0, 0);

    // Trigger
    start_run(1, 4, 100, 11);
    go_to(10); chk("trig_10", as_trig, 0);
    go_to(11); chk("trig_11", as_trig, TRIG_ON);
    go_to(12); chk("trig_12", as_trig, 0);
    as_en = 0; cyc(2);

    // Reset mid-run
    start_run(1, 2, 100, 0);
    go_to(6); bus = ~bus;
    go_to(8); reset_det = 1;
    cyc(1);   reset_det = 0;
    chk("rst_busy", as_busy, 0);
    chk("rst_time", sync_time, 0);
    cyc(1);

    // Random runs, thresholds scrambled mid-run to exercise latching
    for (int r = 0; r < 40; r++) begin
      start_run($urandom % 2, $urandom_range(0, 12),
                ($urandom % 5 == 0) ? 0 : $urandom_range(5, 60), $urandom_range(0, 30));
      for (int k = 0; k < 150 && as_busy; k++) begin
        if ($urandom % 5 == 0) bus = ~bus;
        if ($urandom % 5 == 0) det = ~det;
        if ($urandom % 150 == 0) as_en = 0;
        as_wait = TB'($urandom); as_tmax = TB'($urandom); as_trig_at = TB'($urandom);
        cyc(1);
      end
      if (as_busy) begin as_en = 0; cyc(1); end
      cyc(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
